// File: rtl/multicycle_controller.sv
// Multicycle CPU control FSM: sequences FETCH/DECODE/EXECUTE/MEMORY, drives every
// datapath select and enable, and traps on illegal opcodes or memory wait timeouts.
module multicycle_controller #(
    parameter int MEMORY_HANDSHAKE = 1,
    parameter int MEMORY_LATENCY   = 1,
    parameter int TIMEOUT_CYCLES   = 15,
    parameter int COUNTER_WIDTH    = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] instruction_operation,
    input  logic [3:0] instruction_operation_extra,
    input  logic       condition_met,
    input  logic       memory_ready,
    output logic       memory_request,
    output logic       instruction_address_select,
    output logic       data_address_select,
    output logic       data_write_enable,
    output logic       instruction_write_enable,
    output logic [1:0] alu_a_select,
    output logic [1:0] alu_b_select,
    output logic [2:0] alu_operation,
    output logic       status_write_enable,
    output logic       register_write_enable,
    output logic [2:0] register_write_data_select,
    output logic       program_counter_write_enable,
    output logic [1:0] program_counter_select,
    output logic       illegal_instruction,
    output logic       memory_timeout,
    output logic       halted
);

    localparam logic [2:0] ST_FETCH   = 3'd0;
    localparam logic [2:0] ST_DECODE  = 3'd1;
    localparam logic [2:0] ST_EXECUTE = 3'd2;
    localparam logic [2:0] ST_MEMORY  = 3'd3;
    localparam logic [2:0] ST_TRAP    = 3'd4;

    localparam logic [COUNTER_WIDTH-1:0] LATENCY_LAST = COUNTER_WIDTH'(MEMORY_LATENCY - 1);
    localparam logic [COUNTER_WIDTH-1:0] TIMEOUT_LAST = COUNTER_WIDTH'(TIMEOUT_CYCLES - 1);

    localparam logic [3:0] OP_RTYPE  = 4'b0000;
    localparam logic [3:0] OP_LSH    = 4'b1000;
    localparam logic [3:0] OP_MEMORY = 4'b0100;
    localparam logic [3:0] OP_BCOND  = 4'b1100;
    localparam logic [3:0] OP_MOVI   = 4'b1101;
    localparam logic [3:0] OP_LUI    = 4'b1111;

    localparam logic [3:0] EXT_MOV   = 4'b1101;
    localparam logic [3:0] EXT_LSH   = 4'b0100;
    localparam logic [3:0] EXT_LOAD  = 4'b0000;
    localparam logic [3:0] EXT_STOR  = 4'b0100;
    localparam logic [3:0] EXT_JAL   = 4'b1000;
    localparam logic [3:0] EXT_JCOND = 4'b1100;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_CMP   = 3'b010;
    localparam logic [2:0] ALU_AND   = 3'b011;
    localparam logic [2:0] ALU_OR    = 3'b100;
    localparam logic [2:0] ALU_XOR   = 3'b101;
    localparam logic [2:0] ALU_SHIFT = 3'b110;

    localparam logic [1:0] A_PC       = 2'b00;
    localparam logic [1:0] A_SOURCE   = 2'b01;
    localparam logic [1:0] A_IMM_SEXT = 2'b10;
    localparam logic [1:0] A_IMM_ZEXT = 2'b11;
    localparam logic [1:0] B_DISP     = 2'b10;

    localparam logic [2:0] WD_SOURCE   = 3'b001;
    localparam logic [2:0] WD_IMM_ZEXT = 3'b010;
    localparam logic [2:0] WD_IMM_UP   = 3'b011;
    localparam logic [2:0] WD_MEMORY   = 3'b100;
    localparam logic [2:0] WD_LINK     = 3'b101;

    localparam logic [1:0] PC_INC    = 2'b00;
    localparam logic [1:0] PC_ALU    = 2'b01;
    localparam logic [1:0] PC_SOURCE = 2'b10;

    // {valid, alu op}: the same code space names both the RTYPE extra field and immediate opcodes
    function automatic logic [3:0] alu_code(input logic [3:0] code);
        case (code)
            4'b0101: return {1'b1, ALU_ADD};
            4'b1001: return {1'b1, ALU_SUB};
            4'b1011: return {1'b1, ALU_CMP};
            4'b0001: return {1'b1, ALU_AND};
            4'b0010: return {1'b1, ALU_OR};
            4'b0011: return {1'b1, ALU_XOR};
            default: return 4'b0000;
        endcase
    endfunction

    logic [2:0]               state_q, state_d;
    logic [COUNTER_WIDTH-1:0] count_q, count_d;
    logic                     illegal_q, illegal_d;
    logic                     timeout_q, timeout_d;

    logic [3:0] rtype_code;
    logic [3:0] imm_code;
    logic       op_legal;
    logic       op_memory;
    logic       op_store;
    logic       op_load;
    logic [1:0] ex_alu_a;
    logic [1:0] ex_alu_b;
    logic [2:0] ex_alu_op;
    logic       ex_status_we;
    logic       ex_reg_we;
    logic [2:0] ex_reg_data_select;
    logic [1:0] ex_pc_select;
    logic       mem_done;
    logic       wait_expired;

    assign rtype_code = alu_code(instruction_operation_extra);
    assign imm_code   = alu_code(instruction_operation);

    always_comb begin
        op_legal           = 1'b0;
        op_memory          = 1'b0;
        op_store           = 1'b0;
        op_load            = 1'b0;
        ex_alu_a           = A_PC;
        ex_alu_b           = 2'b00;
        ex_alu_op          = ALU_ADD;
        ex_status_we       = 1'b0;
        ex_reg_we          = 1'b0;
        ex_reg_data_select = 3'b000;
        ex_pc_select       = PC_INC;
        case (instruction_operation)
            OP_RTYPE: begin
                if (rtype_code[3]) begin
                    op_legal     = 1'b1;
                    ex_alu_a     = A_SOURCE;
                    ex_alu_op    = rtype_code[2:0];
                    ex_reg_we    = (rtype_code[2:0] != ALU_CMP);
                    ex_status_we = (rtype_code[2:0] <= ALU_CMP);
                end else if (instruction_operation_extra == EXT_MOV) begin
                    op_legal           = 1'b1;
                    ex_reg_we          = 1'b1;
                    ex_reg_data_select = WD_SOURCE;
                end
            end
            OP_MOVI: begin
                op_legal           = 1'b1;
                ex_reg_we          = 1'b1;
                ex_reg_data_select = WD_IMM_ZEXT;
            end
            OP_LUI: begin
                op_legal           = 1'b1;
                ex_reg_we          = 1'b1;
                ex_reg_data_select = WD_IMM_UP;
            end
            OP_LSH: begin
                if (instruction_operation_extra == EXT_LSH) begin
                    op_legal  = 1'b1;
                    ex_alu_a  = A_SOURCE;
                    ex_alu_op = ALU_SHIFT;
                    ex_reg_we = 1'b1;
                end else if (instruction_operation_extra[3:1] == 3'b000) begin
                    op_legal  = 1'b1;
                    ex_alu_a  = A_IMM_ZEXT;
                    ex_alu_op = ALU_SHIFT;
                    ex_reg_we = 1'b1;
                end
            end
            OP_MEMORY: begin
                case (instruction_operation_extra)
                    EXT_LOAD: begin
                        op_legal  = 1'b1;
                        op_memory = 1'b1;
                        op_load   = 1'b1;
                    end
                    EXT_STOR: begin
                        op_legal  = 1'b1;
                        op_memory = 1'b1;
                        op_store  = 1'b1;
                    end
                    EXT_JAL: begin
                        op_legal           = 1'b1;
                        ex_reg_we          = 1'b1;
                        ex_reg_data_select = WD_LINK;
                        ex_pc_select       = PC_SOURCE;
                    end
                    EXT_JCOND: begin
                        op_legal     = 1'b1;
                        ex_pc_select = condition_met ? PC_SOURCE : PC_INC;
                    end
                    default: op_legal = 1'b0;
                endcase
            end
            OP_BCOND: begin
                op_legal     = 1'b1;
                ex_alu_a     = A_PC;
                ex_alu_b     = B_DISP;
                ex_alu_op    = ALU_ADD;
                ex_pc_select = condition_met ? PC_ALU : PC_INC;
            end
            default: begin
                // Immediate ALU forms: arithmetic sign-extends, logic zero-extends
                if (imm_code[3]) begin
                    op_legal     = 1'b1;
                    ex_alu_a     = (imm_code[2:0] <= ALU_CMP) ? A_IMM_SEXT : A_IMM_ZEXT;
                    ex_alu_op    = imm_code[2:0];
                    ex_reg_we    = (imm_code[2:0] != ALU_CMP);
                    ex_status_we = (imm_code[2:0] <= ALU_CMP);
                end
            end
        endcase
    end

    // Fixed-latency mode ignores memory_ready and never times out
    assign mem_done     = (MEMORY_HANDSHAKE != 0) ? memory_ready : (count_q == LATENCY_LAST);
    assign wait_expired = (MEMORY_HANDSHAKE != 0) && !memory_ready && (count_q == TIMEOUT_LAST);

    always_comb begin
        state_d                      = state_q;
        count_d                      = '0;
        illegal_d                    = illegal_q;
        timeout_d                    = timeout_q;
        memory_request               = 1'b0;
        instruction_address_select   = 1'b0;
        data_address_select          = 1'b0;
        data_write_enable            = 1'b0;
        instruction_write_enable     = 1'b0;
        alu_a_select                 = 2'b00;
        alu_b_select                 = 2'b00;
        alu_operation                = 3'b000;
        status_write_enable          = 1'b0;
        register_write_enable        = 1'b0;
        register_write_data_select   = 3'b000;
        program_counter_write_enable = 1'b0;
        program_counter_select       = 2'b00;
        case (state_q)
            ST_FETCH: begin
                memory_request = 1'b1;
                if (mem_done) begin
                    instruction_write_enable = 1'b1;
                    state_d                  = ST_DECODE;
                end else if (wait_expired) begin
                    timeout_d = 1'b1;
                    state_d   = ST_TRAP;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            ST_DECODE: begin
                if (!op_legal) begin
                    illegal_d = 1'b1;
                    state_d   = ST_TRAP;
                end else if (op_memory) begin
                    state_d = ST_MEMORY;
                end else begin
                    state_d = ST_EXECUTE;
                end
            end
            ST_EXECUTE: begin
                alu_a_select                 = ex_alu_a;
                alu_b_select                 = ex_alu_b;
                alu_operation                = ex_alu_op;
                status_write_enable          = ex_status_we;
                register_write_enable        = ex_reg_we;
                register_write_data_select   = ex_reg_data_select;
                program_counter_write_enable = 1'b1;
                program_counter_select       = ex_pc_select;
                state_d                      = ST_FETCH;
            end
            ST_MEMORY: begin
                memory_request      = 1'b1;
                data_address_select = 1'b1;
                data_write_enable   = op_store;
                if (mem_done) begin
                    program_counter_write_enable = 1'b1;
                    program_counter_select       = PC_INC;
                    register_write_enable        = op_load;
                    register_write_data_select   = op_load ? WD_MEMORY : 3'b000;
                    state_d                      = ST_FETCH;
                end else if (wait_expired) begin
                    timeout_d = 1'b1;
                    state_d   = ST_TRAP;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            ST_TRAP: state_d = ST_TRAP;
            default: state_d = ST_TRAP;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= ST_FETCH;
            count_q   <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
        end
    end

    assign illegal_instruction = illegal_q;
    assign memory_timeout      = timeout_q;
    assign halted              = (state_q == ST_TRAP);

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Parametrised successor to the CPU's multicycle control FSM. It sequences FETCH, DECODE, EXECUTE and MEMORY phases and drives every datapath mux, enable and ALU-op select. Unlike the previous generation, it adds a ready-handshake (or fixed-latency) memory interface, a wait-state timeout, JCOND/JAL support, conditional branches gated by an external condition, and a sticky trap on illegal opcodes.

Parameters:
MEMORY_HANDSHAKE, 1, 1 = a memory access completes when memory_ready=1; 0 = it completes after exactly MEMORY_LATENCY cycles in the state, and memory_ready is ignored.
MEMORY_LATENCY, 1, cycles per memory access in fixed mode (legal range ≥1).
TIMEOUT_CYCLES, 15, handshake mode only: maximum wait cycles before trap (legal range ≥1).
COUNTER_WIDTH, 4, wait-counter width; must hold max(MEMORY_LATENCY, TIMEOUT_CYCLES).

Ports:
clock  input  1  rising-edge clock
reset  input  1  synchronous, active-low
instruction_operation  input  4  opcode [15:12]
instruction_operation_extra  input  4  extended opcode [7:4]
condition_met  input  1  branch/jump condition evaluated by the status unit
memory_ready  input  1  unified memory has accepted or returned the current access
memory_request  output  1  memory access in progress
instruction_address_select  output  1  0=PC, 1=source register
data_address_select  output  1  0=PC, 1=source register
data_write_enable  output  1  store strobe
instruction_write_enable  output  1  load the instruction register
alu_a_select  output  2  00 PC, 01 source, 10 imm sign-ext, 11 imm zero-ext
alu_b_select  output  2  00 destination, 01 const 1, 10 branch displacement
alu_operation  output  3  000 ADD, 001 SUB, 010 CMP, 011 AND, 100 OR, 101 XOR, 110 SHIFT
status_write_enable  output  1  update flags
register_write_enable  output  1  write destination register
register_write_data_select  output  3  000 ALU, 001 source, 010 imm zero-ext, 011 imm upper, 100 memory data, 101 PC+1 (link)
program_counter_write_enable  output  1  update PC
program_counter_select  output  2  00 PC+1, 01 ALU result, 10 source register
illegal_instruction  output  1  sticky; undecodable opcode
memory_timeout  output  1  sticky; handshake wait exceeded TIMEOUT_CYCLES
halted  output  1  FSM is in TRAP

Behaviour:
- Reset (reset=0 at a clock edge): state←FETCH, wait counter←0, sticky flags←0. All outputs are a Moore/Mealy decode of state; default value of every output is 0.
- FETCH: memory_request=1, instruction_address_select=0. On completion (memory_ready=1, or counter=MEMORY_LATENCY-1 in fixed mode), instruction_write_enable=1 in that same cycle, then go to DECODE. Otherwise stay in FETCH with the counter incremented.
- DECODE: one cycle; all enables are 0. Next state is chosen from the opcode map below. An unmapped opcode sets illegal_instruction and goes to TRAP.
- Opcode map: RTYPE (0000) with extra code ADD 0101, SUB 1001, CMP 1011, AND 0001, OR 0010, XOR 0011, MOV 1101. Immediate forms use the opcode equal to the extra code, plus MOVI 1101 and LUI 1111. LSH 1000 with extra 0100 (register) or 000x (immediate). MEMORY 0100 with extra LOAD 0000, STOR 0100, JAL 1000, JCOND 1100. BCOND 1100.
- EXECUTE: one cycle, then FETCH. It always asserts program_counter_write_enable.
  - ALU ops: A = source (register form) or immediate (ADD/SUB/CMP immediates sign-extended; logic/shift immediates zero-extended); B = destination.
  - register_write_enable=1 for every ALU op except CMP/CMPI.
  - status_write_enable=1 for ADD, SUB, CMP and their immediate forms.
  - MOV/MOVI/LUI: register write with select 001/010/011.
  - BCOND: A=PC, B=10, op ADD. program_counter_select=01 if condition_met, else 00.
  - JCOND: program_counter_select=10 if condition_met, else 00.
  - JAL: register_write_enable=1 with select 101; program_counter_select=10.
- MEMORY (LOAD/STOR): memory_request=1, data_address_select=1; STOR also holds data_write_enable=1 throughout. On completion:
  - LOAD asserts register_write_enable with select 100 in the completing cycle.
  - Both assert program_counter_write_enable with select 00.
  - Then go to FETCH.
- Wait counter: cleared on entry to FETCH or MEMORY. In handshake mode, reaching TIMEOUT_CYCLES without memory_ready sets memory_timeout and goes to TRAP. memory_ready arriving in the same cycle the counter hits the limit counts as completion; there is no trap.
- TRAP: halted=1, all enables 0. Only reset exits it.
- reset=0 mid-access takes priority: in the next cycle memory_request and all enables reflect FETCH with counter 0.
- Every instruction updates the PC exactly once.

Test Plan:
- Handshake, ADDI: memory_ready high in the 3rd FETCH cycle → instruction_write_enable exactly on that cycle. EXECUTE shows alu_a=10, op=000, register_write_enable=1, status_write_enable=1, PC select 00.
- Fixed mode, MEMORY_LATENCY=3, LOAD: FETCH lasts 3 cycles, MEMORY lasts 3 cycles. Register write with select 100 occurs only on the 3rd MEMORY cycle.
- BCOND with condition_met=1 → PC select 01, alu_a=00, alu_b=10. With condition_met=0 → PC select 00. JAL → register select 101 and PC select 10 in the same cycle.
- Opcode 0110 → illegal_instruction=1 and halted=1 from the cycle after DECODE, held for 20 cycles. reset=0 clears both on the next edge.
- TIMEOUT_CYCLES=4 with memory_ready held 0 in STOR → memory_timeout=1 after 4 wait cycles, and data_write_enable drops once in TRAP. A second run with ready asserted on the 4th cycle → normal completion, no trap.
- reset=0 asserted during MEMORY → next cycle state is FETCH, data_write_enable=0, memory_request=1.
